// File: rtl/mem_arbiter_n_pkg.sv
// Shared constants for the N-port memory arbiter: idle id, port/id mapping, priority modes
// and the grant-lock state encoding.
package mem_arbiter_n_pkg;

  localparam int ID_NONE    = 0;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Port i travels on the memory side as id i+1 so that id 0 can mean "no port".
  function automatic int port_to_id(input int port);
    return port + 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Rotating-priority picker: grants the first asserted request at or after start,
// wrapping from N-1 back to 0. Returns both one-hot and encoded forms.
module mem_arb_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter with grant lock across stalls, fixed or round-robin priority and
// anti-starvation in fixed mode. Optional MEM_ARB_PERF_EN adds per-port stall counters.
//
// state      | meaning
// ARB_FREE   | no stalled grant held; arbitrate afresh every cycle
// ARB_LOCKED | grantee stalled last cycle; keep locked_port while it still strobes
module mem_arbiter_n
  import mem_arbiter_n_pkg::*;
#(
  parameter int N          = 2,
  parameter int IDW        = 2,
  parameter int RR         = 0,
  parameter int MAX_CONSEC = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [N*30-1:0]   req_address,
  input  logic [N-1:0]      req_read,
  input  logic [N-1:0]      req_write,
  input  logic [N*32-1:0]   req_writedata,
  input  logic [N*4-1:0]    req_writedatamask,
  output logic [N-1:0]      req_waitrequest,
  output logic [31:0]       req_readdata,
  output logic [N-1:0]      req_readdatavalid,
  input  logic              mem_waitrequest,
  output logic [IDW-1:0]    mem_id,
  output logic [29:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_writedatamask,
  input  logic [31:0]       mem_readdata,
  input  logic [IDW-1:0]    mem_readdataid
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [N*32-1:0]   perf_wait
`endif
);

  localparam int IW = $clog2(N);
  localparam int CW = 8;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] locked_port_q, locked_port_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] last_port_q, last_port_d;
  logic [CW-1:0] consec_q, consec_d;

  logic [N-1:0]  strobe;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  starve_req;
  logic [IW-1:0] pick_start, starve_start;
  logic [N-1:0]  pick_gnt, starve_gnt;
  logic [IW-1:0] pick_idx, starve_idx;
  logic          pick_valid, starve_valid;
  logic          lock_hit, starve_now;
  logic [IW-1:0] grant;
  logic [N-1:0]  grant_oh;
  logic          grant_valid;
  logic          hi_wait_grant;
  logic          accept;

  // Ports above the last accepted one are the candidates the starvation bound protects.
  always_comb begin
    strobe  = req_read | req_write;
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i > int'(last_port_q));
    end
    starve_req   = strobe & hi_mask;
    pick_start   = (RR == MODE_RR) ? rr_ptr_q : '0;
    starve_start = IW'((int'(last_port_q) + 1) % N);
  end

  mem_arb_pick #(.N(N), .IW(IW)) u_pick_main (
    .req   (strobe),
    .start (pick_start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  mem_arb_pick #(.N(N), .IW(IW)) u_pick_starve (
    .req   (starve_req),
    .start (starve_start),
    .gnt   (starve_gnt),
    .idx   (starve_idx),
    .valid (starve_valid)
  );

  always_comb begin
    lock_hit    = (state_q == ARB_LOCKED) && strobe[locked_port_q];
    starve_now  = (RR == MODE_FIXED) && (consec_q == CW'(MAX_CONSEC)) && starve_valid;
    grant       = '0;
    grant_oh    = '0;
    grant_valid = 1'b0;
    if (lock_hit) begin
      grant                   = locked_port_q;
      grant_oh[locked_port_q] = 1'b1;
      grant_valid             = 1'b1;
    end else if (starve_now) begin
      grant       = starve_idx;
      grant_oh    = starve_gnt;
      grant_valid = 1'b1;
    end else begin
      grant       = pick_idx;
      grant_oh    = pick_gnt;
      grant_valid = pick_valid;
    end
  end

  always_comb begin
    mem_id            = IDW'(ID_NONE);
    mem_address       = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = '0;
    mem_writedatamask = '0;
    if (grant_valid) begin
      mem_id            = IDW'(port_to_id(int'(grant)));
      mem_address       = req_address[30*int'(grant) +: 30];
      mem_read          = req_read[grant];
      mem_write         = req_write[grant];
      mem_writedata     = req_writedata[32*int'(grant) +: 32];
      mem_writedatamask = req_writedatamask[4*int'(grant) +: 4];
    end
    accept          = (mem_read | mem_write) & ~mem_waitrequest;
    req_waitrequest = ~grant_oh | {N{mem_waitrequest}};
  end

  // Responses are routed purely by tag, so reads issued before a reset still land.
  always_comb begin
    req_readdata = mem_readdata;
    for (int i = 0; i < N; i++) begin
      req_readdatavalid[i] = (mem_readdataid == IDW'(port_to_id(i)));
    end
  end

  always_comb begin
    hi_wait_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(grant) && strobe[i]) hi_wait_grant = 1'b1;
    end
  end

  always_comb begin
    state_d       = ARB_FREE;
    locked_port_d = locked_port_q;
    rr_ptr_d      = rr_ptr_q;
    last_port_d   = last_port_q;
    consec_d      = consec_q;
    if (grant_valid && mem_waitrequest) begin
      state_d       = ARB_LOCKED;
      locked_port_d = grant;
    end
    if (accept) begin
      last_port_d = grant;
      if (RR == MODE_RR) rr_ptr_d = IW'((int'(grant) + 1) % N);
    end
    // A grantee change restarts the count with the accept just made.
    if (RR == MODE_FIXED) begin
      if (accept) begin
        if (!hi_wait_grant)                       consec_d = '0;
        else if (grant != last_port_q)            consec_d = CW'(1);
        else if (consec_q != CW'(MAX_CONSEC))     consec_d = consec_q + 1'b1;
      end else if (!starve_valid) begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= ARB_FREE;
      locked_port_q <= '0;
      rr_ptr_q      <= '0;
      last_port_q   <= '0;
      consec_q      <= '0;
    end else begin
      state_q       <= state_d;
      locked_port_q <= locked_port_d;
      rr_ptr_q      <= rr_ptr_d;
      last_port_q   <= last_port_d;
      consec_q      <= consec_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_q [N];
  logic [31:0] perf_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      perf_d[i] = perf_q[i];
      if (strobe[i] && req_waitrequest[i] && (perf_q[i] != '1)) perf_d[i] = perf_q[i] + 1'b1;
      perf_wait[32*i +: 32] = perf_q[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (rst) perf_q[i] <= '0;
      else     perf_q[i] <= perf_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: a 2-port fixed-priority instance and a 4-port round-robin
// instance. Inputs change on the falling edge and outputs are checked shortly after.
module tb_mem_arbiter_n;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // fixed-priority, N=2
  logic [59:0]  fx_addr = '0;
  logic [1:0]   fx_rd = '0, fx_wr = '0;
  logic [63:0]  fx_wd = '0;
  logic [7:0]   fx_wm = '0;
  logic [1:0]   fx_wait;
  logic [31:0]  fx_rdata;
  logic [1:0]   fx_rvalid;
  logic         fx_mwait = 1'b0;
  logic [1:0]   fx_mid;
  logic [29:0]  fx_maddr;
  logic         fx_mrd, fx_mwr;
  logic [31:0]  fx_mwd;
  logic [3:0]   fx_mwm;
  logic [31:0]  fx_mrdata = '0;
  logic [1:0]   fx_mrid = '0;

  // round-robin, N=4
  logic [119:0] rr_addr = '0;
  logic [3:0]   rr_rd = '0, rr_wr = '0;
  logic [127:0] rr_wd = '0;
  logic [15:0]  rr_wm = '0;
  logic [3:0]   rr_wait;
  logic [31:0]  rr_rdata;
  logic [3:0]   rr_rvalid;
  logic         rr_mwait = 1'b0;
  logic [2:0]   rr_mid;
  logic [29:0]  rr_maddr;
  logic         rr_mrd, rr_mwr;
  logic [31:0]  rr_mwd;
  logic [3:0]   rr_mwm;
  logic [31:0]  rr_mrdata = '0;
  logic [2:0]   rr_mrid = '0;

`ifdef MEM_ARB_PERF_EN
  logic [63:0]  fx_perf;
  logic [127:0] rr_perf;
`endif

  mem_arbiter_n #(.N(2), .IDW(2), .RR(0), .MAX_CONSEC(8)) dut_fx (
    .clock(clock), .rst(rst),
    .req_address(fx_addr), .req_read(fx_rd), .req_write(fx_wr),
    .req_writedata(fx_wd), .req_writedatamask(fx_wm),
    .req_waitrequest(fx_wait), .req_readdata(fx_rdata), .req_readdatavalid(fx_rvalid),
    .mem_waitrequest(fx_mwait), .mem_id(fx_mid), .mem_address(fx_maddr),
    .mem_read(fx_mrd), .mem_write(fx_mwr), .mem_writedata(fx_mwd),
    .mem_writedatamask(fx_mwm), .mem_readdata(fx_mrdata), .mem_readdataid(fx_mrid)
`ifdef MEM_ARB_PERF_EN
    , .perf_wait(fx_perf)
`endif
  );

  mem_arbiter_n #(.N(4), .IDW(3), .RR(1), .MAX_CONSEC(8)) dut_rr (
    .clock(clock), .rst(rst),
    .req_address(rr_addr), .req_read(rr_rd), .req_write(rr_wr),
    .req_writedata(rr_wd), .req_writedatamask(rr_wm),
    .req_waitrequest(rr_wait), .req_readdata(rr_rdata), .req_readdatavalid(rr_rvalid),
    .mem_waitrequest(rr_mwait), .mem_id(rr_mid), .mem_address(rr_maddr),
    .mem_read(rr_mrd), .mem_write(rr_mwr), .mem_writedata(rr_mwd),
    .mem_writedatamask(rr_mwm), .mem_readdata(rr_mrdata), .mem_readdataid(rr_mrid)
`ifdef MEM_ARB_PERF_EN
    , .perf_wait(rr_perf)
`endif
  );

  // Stall monitor: while the memory side holds waitrequest, the presented beat must not move.
  logic        fx_prev_stall = 1'b0;
  logic        fx_prev_rst   = 1'b1;
  logic [1:0]  fx_prev_id    = '0;
  logic [29:0] fx_prev_addr  = '0;
  logic [31:0] fx_prev_wd    = '0;
  always begin
    @(negedge clock);
    #3;
    if (fx_prev_stall && !rst && !fx_prev_rst) begin
      check_eq("stall_id", 64'(fx_mid), 64'(fx_prev_id));
      check_eq("stall_addr", 64'(fx_maddr), 64'(fx_prev_addr));
      check_eq("stall_wdata", 64'(fx_mwd), 64'(fx_prev_wd));
    end
    fx_prev_stall = (fx_mrd | fx_mwr) & fx_mwait;
    fx_prev_rst   = rst;
    fx_prev_id    = fx_mid;
    fx_prev_addr  = fx_maddr;
    fx_prev_wd    = fx_mwd;
  end

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fx_rd = '0; fx_wr = '0; fx_mwait = 1'b0; fx_mrid = '0;
    rr_rd = '0; rr_wr = '0; rr_mwait = 1'b0; rr_mrid = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_id;

    fx_addr = {30'h200, 30'h100};
    fx_wd   = {32'h1111_2222, 32'h3333_4444};
    fx_wm   = 8'b1010_0101;
    for (int i = 0; i < 4; i++) begin
      rr_addr[30*i +: 30] = 30'(32'h40 + i);
      rr_wd[32*i +: 32]   = 32'hC0DE_0000 + i;
      rr_wm[4*i +: 4]     = 4'(i + 1);
    end

    // reset state
    do_reset();
    #1;
    check_eq("rst_mem_id", 64'(fx_mid), 64'd0);
    check_eq("rst_mem_read", 64'(fx_mrd), 64'd0);
    check_eq("rst_mem_write", 64'(fx_mwr), 64'd0);
    check_eq("rst_waitreq", 64'(fx_wait), 64'b11);

    // fixed mode: 8 accepts for port0, 9th to port1, repeating
    next_cycle();
    fx_rd = 2'b11;
    for (int c = 0; c < 18; c++) begin
      #1;
      exp_id = (c % 9 == 8) ? 2'd2 : 2'd1;
      check_eq("fx_starve_id", 64'(fx_mid), 64'(exp_id));
      check_eq("fx_starve_addr", 64'(fx_maddr), (exp_id == 2'd2) ? 64'h200 : 64'h100);
      next_cycle();
    end

    // port0 alone must not build up starvation credit
    do_reset();
    fx_rd = 2'b01;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq("fx_solo_id", 64'(fx_mid), 64'd1);
      next_cycle();
    end
    fx_rd = 2'b11;
    for (int c = 0; c < 9; c++) begin
      #1;
      check_eq("fx_join_id", 64'(fx_mid), (c == 8) ? 64'd2 : 64'd1);
      next_cycle();
    end

    // grant lock across a 3-cycle stall
    do_reset();
    fx_addr = {30'h2AA, 30'h155};
    fx_rd = 2'b10; fx_mwait = 1'b1;
    #1;
    check_eq("lock_c1_id", 64'(fx_mid), 64'd2);
    check_eq("lock_c1_mask", 64'(fx_mwm), 64'hA);
    next_cycle();
    fx_rd = 2'b11;
    #1;
    check_eq("lock_c2_id", 64'(fx_mid), 64'd2);
    check_eq("lock_c2_wait", 64'(fx_wait), 64'b11);
    next_cycle();
    #1;
    check_eq("lock_c3_id", 64'(fx_mid), 64'd2);
    next_cycle();
    fx_mwait = 1'b0;
    #1;
    check_eq("lock_acc_id", 64'(fx_mid), 64'd2);
    check_eq("lock_acc_addr", 64'(fx_maddr), 64'h2AA);
    check_eq("lock_acc_wait", 64'(fx_wait), 64'b01);
    next_cycle();
    fx_rd = 2'b01;
    #1;
    check_eq("lock_next_id", 64'(fx_mid), 64'd1);
    check_eq("lock_next_addr", 64'(fx_maddr), 64'h155);
    check_eq("lock_next_rd", 64'(fx_mrd), 64'd1);

    // round-robin over four writers
    do_reset();
    rr_wr = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      #1;
      check_eq("rr_id", 64'(rr_mid), 64'((c % 4) + 1));
      check_eq("rr_wdata", 64'(rr_mwd), 64'(32'hC0DE_0000 + (c % 4)));
      check_eq("rr_mask", 64'(rr_mwm), 64'((c % 4) + 1));
      check_eq("rr_wr_rd", 64'({rr_mwr, rr_mrd}), 64'b10);
      next_cycle();
    end
    rr_wr = 4'b0000;

    // response routing
    fx_mrdata = 32'hDEAD_BEEF; fx_mrid = 2'd2;
    #1;
    check_eq("route_id2_valid", 64'(fx_rvalid), 64'b10);
    check_eq("route_id2_data", 64'(fx_rdata), 64'hDEAD_BEEF);
    fx_mrid = 2'd3;
    #1;
    check_eq("route_id3_valid", 64'(fx_rvalid), 64'b00);
    fx_mrid = 2'd1;
    #1;
    check_eq("route_id1_valid", 64'(fx_rvalid), 64'b01);
    fx_mrid = 2'd0;
    #1;
    check_eq("route_id0_valid", 64'(fx_rvalid), 64'b00);
    rr_mrdata = 32'h0BAD_F00D; rr_mrid = 3'd4;
    #1;
    check_eq("route_rr4_valid", 64'(rr_rvalid), 64'b1000);
    check_eq("route_rr4_data", 64'(rr_rdata), 64'h0BAD_F00D);
    rr_mrid = 3'd5;
    #1;
    check_eq("route_rr5_valid", 64'(rr_rvalid), 64'b0000);
    rr_mrid = 3'd0;

    // reset during a locked stall
    do_reset();
    fx_rd = 2'b10; fx_mwait = 1'b1;
    #1;
    check_eq("rstlk_c1_id", 64'(fx_mid), 64'd2);
    next_cycle();
    rst = 1'b1; fx_rd = 2'b11;
    fx_mrdata = 32'hCAFE_F00D; fx_mrid = 2'd2;
    #1;
    check_eq("rstlk_route_valid", 64'(fx_rvalid), 64'b10);
    check_eq("rstlk_route_data", 64'(fx_rdata), 64'hCAFE_F00D);
    next_cycle();
    rst = 1'b0; fx_mwait = 1'b0; fx_mrid = 2'd0;
    #1;
    check_eq("rstlk_after_id", 64'(fx_mid), 64'd1);
    check_eq("rstlk_after_wait", 64'(fx_wait), 64'b10);

`ifdef MEM_ARB_PERF_EN
    // port1 waits five cycles behind port0
    do_reset();
    fx_rd = 2'b11;
    for (int c = 0; c < 5; c++) next_cycle();
    fx_rd = 2'b00;
    #1;
    check_eq("perf_p1", 64'(fx_perf[63:32]), 64'd5);
    check_eq("perf_p0", 64'(fx_perf[31:0]), 64'd0);
    do_reset();
    #1;
    check_eq("perf_rst", 64'(fx_perf[63:32]), 64'd0);
`endif

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
